bundle_fetch_ctrl: RTL and testbench

// Fetch sequencer in front of the dual-issue bundle parser. Owns the PC, fetches an 8-byte window
// per bundle, hands bits [63:4] to the parser with a 1-cycle enable, advances PC by the decoded

---
 rtl/pa_fetch_pkg.sv | 20 ++
 rtl/bundle_size_decode.sv | 29 ++
 rtl/bundle_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_bundle_fetch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_fetch_pkg.sv
// Shared types and constants for the bundle fetch path: FSM states, bundle lengths
// and the widths of the fetch window and the parser instruction field.
package pa_fetch_pkg;

  localparam int WINDOW_W = 64;
  localparam int INSTR_W  = 60;

  localparam logic [3:0] BUNDLE_5B = 4'd5;
  localparam logic [3:0] BUNDLE_7B = 4'd7;
  localparam logic [3:0] BUNDLE_8B = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/bundle_size_decode.sv
// Combinational bundle length decode from an 8-byte fetch window whose first
// bundle bit sits at [63]. Reusable by any block that needs to check a bundle length.
module bundle_size_decode
  import pa_fetch_pkg::*;
(
  input  logic [WINDOW_W-1:0] window,
  output logic [3:0]          size
);

  logic f1;
  logic f2;
  logic unused_bits;

  // Instr-2 format bit follows a 19-bit (f1=0) or 30-bit (f1=1) instr-1.
  assign f1 = window[63];
  assign f2 = f1 ? window[33] : window[44];

  assign unused_bits = ^{window[62:45], window[43:34], window[32:0]};

  // NOTE: the default arm gives size a value on every path, so no latch is inferred.
  always_comb begin
    case ({f1, f2})
      2'b00:   size = BUNDLE_5B;
      2'b11:   size = BUNDLE_8B;
      default: size = BUNDLE_7B;
    endcase
  end

endmodule

// File: rtl/bundle_fetch_ctrl.sv
// Fetch sequencer ahead of the dual-issue bundle parser: owns the PC, fetches one
// 8-byte window per bundle, issues it with a 1-cycle enable and handles redirects.
module bundle_fetch_ctrl
  import pa_fetch_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                run_i,
  input  logic                stall_i,
  input  logic                branchValid_i,
  input  logic [ADDR_W-1:0]   branchTarget_i,
  output logic                memReq_o,
  output logic [ADDR_W-1:0]   memAddr_o,
  input  logic                memReady_i,
  input  logic                memValid_i,
  input  logic [WINDOW_W-1:0] memData_i,
  output logic [INSTR_W-1:0]  parserInstr_o,
  output logic                parserEnable_o,
  output logic                parserFlush_o,
  output logic [3:0]          bundleSize_o,
  output logic [ADDR_W-1:0]   pc_o
);

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [3:0]         size_q;
  logic [3:0]         win_size;
  logic               resp_pending;

  bundle_size_decode u_size_decode (
    .window (memData_i),
    .size   (win_size)
  );

  // A redirect must still swallow a response that was accepted but has not arrived.
  assign resp_pending = (state == ST_FETCH && memReady_i) ||
                        ((state == ST_WAIT || state == ST_DRAIN) && !memValid_i);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state          <= ST_IDLE;
      pc_q           <= RESET_PC;
      memReq_o       <= 1'b0;
      parserEnable_o <= 1'b0;
      parserFlush_o  <= 1'b0;
      // NOTE: the captured window is reset because it drives a port directly;
      // a deep data store would normally be left unreset.
      instr_q        <= '0;
      size_q         <= '0;
    end else begin
      parserEnable_o <= 1'b0;
      parserFlush_o  <= 1'b0;
      if (branchValid_i) begin
        pc_q          <= branchTarget_i;
        parserFlush_o <= 1'b1;
        if (resp_pending) begin
          state    <= ST_DRAIN;
          memReq_o <= 1'b0;
        end else begin
          state    <= run_i ? ST_FETCH : ST_IDLE;
          memReq_o <= run_i;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (run_i) begin
              state    <= ST_FETCH;
              memReq_o <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (memReady_i) begin
              state    <= ST_WAIT;
              memReq_o <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (memValid_i) begin
              instr_q <= memData_i[WINDOW_W-1:4];
              size_q  <= win_size;
              state   <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (!stall_i) begin
              parserEnable_o <= 1'b1;
              pc_q           <= pc_q + ADDR_W'(size_q);
              state          <= run_i ? ST_FETCH : ST_IDLE;
              memReq_o       <= run_i;
            end
          end
          ST_DRAIN: begin
            if (memValid_i) begin
              state    <= run_i ? ST_FETCH : ST_IDLE;
              memReq_o <= run_i;
            end
          end
          default: begin
            state    <= ST_IDLE;
            memReq_o <= 1'b0;
          end
        endcase
      end
    end
  end

  assign memAddr_o     = pc_q;
  assign pc_o          = pc_q;
  assign parserInstr_o = instr_q;
  assign bundleSize_o  = size_q;

endmodule

// File: tb/tb_bundle_fetch_ctrl.sv
// Directed bench for bundle_fetch_ctrl: the bench plays the memory, pushes the expected
// bundle into a scoreboard on each response and a monitor pops it on every parser enable.
module tb_bundle_fetch_ctrl;

  logic        clock_i;
  logic        reset_ni;
  logic        run_i;
  logic        stall_i;
  logic        branchValid_i;
  logic [15:0] branchTarget_i;
  logic        memReq_o;
  logic [15:0] memAddr_o;
  logic        memReady_i;
  logic        memValid_i;
  logic [63:0] memData_i;
  logic [59:0] parserInstr_o;
  logic        parserEnable_o;
  logic        parserFlush_o;
  logic [3:0]  bundleSize_o;
  logic [15:0] pc_o;

  typedef struct packed {
    logic [59:0] instr;
    logic [3:0]  size;
    logic [15:0] pc_after;
  } exp_t;

  exp_t        sb[$];
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          n_enable = 0;
  int          n_pushed = 0;
  logic [15:0] exp_pc;
  logic [63:0] win;

  bundle_fetch_ctrl #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clock_i        (clock_i),
    .reset_ni       (reset_ni),
    .run_i          (run_i),
    .stall_i        (stall_i),
    .branchValid_i  (branchValid_i),
    .branchTarget_i (branchTarget_i),
    .memReq_o       (memReq_o),
    .memAddr_o      (memAddr_o),
    .memReady_i     (memReady_i),
    .memValid_i     (memValid_i),
    .memData_i      (memData_i),
    .parserInstr_o  (parserInstr_o),
    .parserEnable_o (parserEnable_o),
    .parserFlush_o  (parserFlush_o),
    .bundleSize_o   (bundleSize_o),
    .pc_o           (pc_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock_i);
  endtask

  // Window with chosen format bits; the unselected f2 position gets the opposite value.
  function automatic logic [63:0] mk_window(input bit f1, input bit f2, input logic [63:0] seed);
    logic [63:0] w;
    w     = seed;
    w[63] = f1;
    if (f1) begin
      w[33] = f2;
      w[44] = ~f2;
    end else begin
      w[44] = f2;
      w[33] = ~f2;
    end
    return w;
  endfunction

  task automatic push_exp(input logic [63:0] w, input logic [3:0] size);
    exp_t e;
    exp_pc     = exp_pc + 16'(size);
    e.instr    = w[63:4];
    e.size     = size;
    e.pc_after = exp_pc;
    sb.push_back(e);
    n_pushed++;
  endtask

  task automatic wait_req(input logic [15:0] addr);
    int n = 0;
    while (memReq_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", memReq_o, 1);
    check("req_addr", memAddr_o, addr);
  endtask

  task automatic fetch_bundle(input logic [15:0] addr, input logic [63:0] w,
                              input logic [3:0] size, input int ready_dly, input bit stall3);
    logic [15:0] pc_before;
    wait_req(addr);
    repeat (ready_dly) begin
      tick();
      check("req_held", memReq_o, 1);
      check("addr_held", memAddr_o, addr);
    end
    memReady_i = 1'b1;
    tick();
    memReady_i = 1'b0;
    pc_before  = exp_pc;
    memValid_i = 1'b1;
    memData_i  = w;
    push_exp(w, size);
    if (stall3) stall_i = 1'b1;
    tick();
    memValid_i = 1'b0;
    if (stall3) begin
      repeat (3) begin
        tick();
        check("stall_no_enable", parserEnable_o, 0);
        check("stall_pc_hold", pc_o, pc_before);
      end
      stall_i = 1'b0;
    end
    tick();
    check("enable_pulse", parserEnable_o, 1);
  endtask

  // Scoreboard monitor: every parser enable must match the oldest expected bundle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_i);
      if (parserEnable_o === 1'b1) begin
        n_enable++;
        if (sb.size() == 0) begin
          check("enable_unexpected", parserEnable_o, 0);
        end else begin
          e = sb.pop_front();
          check("sb_instr", parserInstr_o, e.instr);
          check("sb_size", bundleSize_o, e.size);
          check("sb_pc", pc_o, e.pc_after);
        end
      end
    end
  end

  initial begin
    reset_ni       = 1'b0;
    run_i          = 1'b0;
    stall_i        = 1'b0;
    branchValid_i  = 1'b0;
    branchTarget_i = 16'h0000;
    memReady_i     = 1'b0;
    memValid_i     = 1'b0;
    memData_i      = 64'h0;
    exp_pc         = 16'h0000;

    repeat (3) tick();
    check("rst_req", memReq_o, 0);
    check("rst_enable", parserEnable_o, 0);
    check("rst_flush", parserFlush_o, 0);
    check("rst_instr", parserInstr_o, 0);
    check("rst_size", bundleSize_o, 0);
    check("rst_pc", pc_o, 16'h0000);
    reset_ni = 1'b1;
    run_i    = 1'b1;

    // Sequential sizes 5, 7, 8, 7 from PC 0; first request waits for ready.
    fetch_bundle(16'h0000, mk_window(0, 0, 64'h0123_4567_89AB_CDEF), 4'd5, 3, 1'b0);
    fetch_bundle(16'h0005, mk_window(1, 0, 64'hFEDC_BA98_7654_3210), 4'd7, 0, 1'b0);
    fetch_bundle(16'h000C, mk_window(1, 1, 64'h5A5A_A5A5_3C3C_C3C3), 4'd8, 1, 1'b0);
    fetch_bundle(16'h0014, mk_window(0, 1, 64'h0F0F_F0F0_1234_5678), 4'd7, 0, 1'b0);

    // Three stalled ISSUE cycles.
    fetch_bundle(16'h001B, mk_window(1, 1, 64'h1111_2222_3333_4444), 4'd8, 0, 1'b1);

    // Redirect in WAIT: flush, drain the stale response, refetch at the target.
    wait_req(exp_pc);
    memReady_i = 1'b1;
    tick();
    memReady_i     = 1'b0;
    branchValid_i  = 1'b1;
    branchTarget_i = 16'h0100;
    tick();
    branchValid_i = 1'b0;
    exp_pc        = 16'h0100;
    check("redir_flush", parserFlush_o, 1);
    check("redir_pc", pc_o, 16'h0100);
    check("redir_drain_noreq", memReq_o, 0);
    repeat (2) tick();
    check("redir_flush_pulse", parserFlush_o, 0);
    check("drain_noreq", memReq_o, 0);
    memValid_i = 1'b1;
    memData_i  = mk_window(1, 1, 64'hDEAD_BEEF_DEAD_BEEF);
    tick();
    memValid_i = 1'b0;
    check("drain_refetch", memReq_o, 1);
    check("drain_addr", memAddr_o, 16'h0100);
    fetch_bundle(16'h0100, mk_window(1, 0, 64'h2468_ACE0_1357_9BDF), 4'd7, 0, 1'b0);

    // Redirect while a request is unaccepted, then wrap 0xFFFC + 8 -> 0x0004.
    wait_req(exp_pc);
    branchValid_i  = 1'b1;
    branchTarget_i = 16'hFFFC;
    tick();
    branchValid_i = 1'b0;
    exp_pc        = 16'hFFFC;
    check("fetch_redir_flush", parserFlush_o, 1);
    check("fetch_redir_req", memReq_o, 1);
    check("fetch_redir_addr", memAddr_o, 16'hFFFC);
    fetch_bundle(16'hFFFC, mk_window(1, 1, 64'h7777_8888_9999_AAAA), 4'd8, 0, 1'b0);
    check("wrap_pc", pc_o, 16'h0004);

    // Redirect coinciding with the response: dropped, no DRAIN.
    wait_req(16'h0004);
    memReady_i = 1'b1;
    tick();
    memReady_i     = 1'b0;
    memValid_i     = 1'b1;
    memData_i      = mk_window(0, 1, 64'hCAFE_F00D_CAFE_F00D);
    branchValid_i  = 1'b1;
    branchTarget_i = 16'h0200;
    tick();
    memValid_i    = 1'b0;
    branchValid_i = 1'b0;
    exp_pc        = 16'h0200;
    check("coinc_flush", parserFlush_o, 1);
    check("coinc_req", memReq_o, 1);
    check("coinc_addr", memAddr_o, 16'h0200);
    tick();
    check("coinc_no_enable", parserEnable_o, 0);
    fetch_bundle(16'h0200, mk_window(0, 1, 64'h1357_2468_1357_2468), 4'd7, 0, 1'b0);

    // run_i falls after acceptance: bundle still issues, no new request.
    wait_req(exp_pc);
    memReady_i = 1'b1;
    tick();
    memReady_i = 1'b0;
    run_i      = 1'b0;
    win        = mk_window(0, 0, 64'h4242_4242_4242_4242);
    memValid_i = 1'b1;
    memData_i  = win;
    push_exp(win, 4'd5);
    tick();
    memValid_i = 1'b0;
    tick();
    check("runoff_enable", parserEnable_o, 1);
    repeat (3) begin
      tick();
      check("runoff_no_req", memReq_o, 0);
    end
    run_i = 1'b1;

    // Reset mid-WAIT: everything clears at once, stale response ignored afterwards.
    wait_req(16'h020C);
    memReady_i = 1'b1;
    tick();
    memReady_i = 1'b0;
    reset_ni   = 1'b0;
    #1;
    check("midrst_req", memReq_o, 0);
    check("midrst_instr", parserInstr_o, 0);
    check("midrst_size", bundleSize_o, 0);
    check("midrst_pc", pc_o, 16'h0000);
    check("midrst_addr", memAddr_o, 16'h0000);
    check("midrst_enable", parserEnable_o, 0);
    run_i = 1'b0;
    tick();
    reset_ni = 1'b1;
    tick();
    memValid_i = 1'b1;
    memData_i  = mk_window(1, 1, 64'h9999_9999_9999_9999);
    tick();
    memValid_i = 1'b0;
    repeat (3) begin
      tick();
      check("postrst_no_enable", parserEnable_o, 0);
      check("postrst_no_req", memReq_o, 0);
    end

    check("sb_empty", sb.size(), 0);
    check("enable_count", n_enable, n_pushed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
